// File: rtl/window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_gen_pkg
// Description : Shared convolution-pipeline definitions. Holds the default
//               pixel word width and image size, the 3x3 window size and the
//               pixel word type.
// Revision    : 1.0 - initial release
// ============================================================================
package window_gen_pkg;
  localparam int INT_BITS_DEF   = 13;  // pixel word width, matches stage0
  localparam int WIN_SIZE       = 9;   // 3x3 neighbourhood
  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;

  typedef logic [INT_BITS_DEF-1:0] pixel_t;
endpackage
`default_nettype wire

// File: rtl/window_gen_line_delay.sv
`default_nettype none
// ============================================================================
// Module      : window_gen_line_delay
// Description : One image row of pixel storage, a circular buffer indexed by
//               the column counter. The read is asynchronous, so o_dout shows
//               the word written one row earlier at the same column, until the
//               write at that column lands on the clock edge.
// Ports       : clk    - rising-edge clock
//               i_we   - write enable (pixel accepted)
//               i_addr - column index
//               i_din  - word to store
//               o_dout - word previously stored at i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen_line_delay
  import window_gen_pkg::*;
#(
  parameter int int_bits = INT_BITS_DEF,
  parameter int depth    = IMG_WIDTH_DEF,
  parameter int AW       = $clog2(depth)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [int_bits-1:0] i_din,
  output logic [int_bits-1:0] o_dout
);

  // No reset: contents are always rewritten before they reach a window.
  logic [int_bits-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_gen
// Description : Raster-scan 3x3 window generator. Buffers the two previous
//               rows in chained line delays and emits a full neighbourhood,
//               one cycle after each accepted pixel whose window lies fully
//               inside the frame.
// Ports       : clk         - rising-edge clock
//               reset       - asynchronous active-low reset
//               pix_in      - raster pixel, row-major, top-left first
//               pix_valid   - pix_in accepted this cycle (no backpressure)
//               win_out     - 3x3 window, index 3*r + c, [8] = newest pixel
//               latency_out - win_out valid for exactly this cycle
//               frame_done  - pulse with the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen
  import window_gen_pkg::*;
#(
  parameter int int_bits   = INT_BITS_DEF,
  parameter int img_width  = IMG_WIDTH_DEF,
  parameter int img_height = IMG_HEIGHT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [int_bits-1:0] pix_in,
  input  logic                pix_valid,
  output logic [int_bits-1:0] win_out [WIN_SIZE],
  output logic                latency_out,
  output logic                frame_done
);

  localparam int CW = $clog2(img_width);
  localparam int RW = $clog2(img_height);

  localparam logic [CW-1:0] c_COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(img_height - 1);
  localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);

  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [int_bits-1:0] r_win [WIN_SIZE];
  logic [int_bits-1:0] w_lb0;  // row-1 at this column
  logic [int_bits-1:0] w_lb1;  // row-2 at this column

  // linebuf0 stores the incoming pixel; linebuf1 takes what linebuf0 held.
  window_gen_line_delay #(
    .int_bits (int_bits),
    .depth    (img_width),
    .AW       (CW)
  ) u_linebuf0 (
    .clk    (clk),
    .i_we   (pix_valid),
    .i_addr (r_col),
    .i_din  (pix_in),
    .o_dout (w_lb0)
  );

  window_gen_line_delay #(
    .int_bits (int_bits),
    .depth    (img_width),
    .AW       (CW)
  ) u_linebuf1 (
    .clk    (clk),
    .i_we   (pix_valid),
    .i_addr (r_col),
    .i_din  (w_lb0),
    .o_dout (w_lb1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col       <= '0;
      r_row       <= '0;
      latency_out <= 1'b0;
      frame_done  <= 1'b0;
      for (int k = 0; k < WIN_SIZE; k++) begin
        r_win[k] <= '0;
      end
    end else begin
      // Window validity uses the counters before this pixel advances them.
      latency_out <= pix_valid && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
      frame_done  <= pix_valid && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

      if (pix_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]   <= r_win[3*r+1];
          r_win[3*r+1] <= r_win[3*r+2];
        end
        r_win[2] <= w_lb1;
        r_win[5] <= w_lb0;
        r_win[8] <= pix_in;

        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign win_out = r_win;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_gen
// Description : Self-checking bench. DUT0 is a 4x4 image for directed frames,
//               DUT1 is 32x32 with random pixels. A behavioural model keeps
//               each frame as a 2-D image and cuts the expected window
//               straight out of it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen;
  localparam int IB = 13;
  localparam int W0 = 4;
  localparam int H0 = 4;
  localparam int W1 = 32;
  localparam int H1 = 32;

  typedef logic [IB-1:0] win_t [9];

  logic          clk = 1'b0;
  logic          rst_n0, rst_n1;
  logic [IB-1:0] pix0, pix1;
  logic          pv0, pv1;
  logic [IB-1:0] win0 [9];
  logic [IB-1:0] win1 [9];
  logic          lat0, lat1, fd0, fd1;

  always #5 clk = ~clk;

  window_gen #(.int_bits(IB), .img_width(W0), .img_height(H0)) u_dut0 (
    .clk(clk), .reset(rst_n0), .pix_in(pix0), .pix_valid(pv0),
    .win_out(win0), .latency_out(lat0), .frame_done(fd0)
  );

  window_gen #(.int_bits(IB), .img_width(W1), .img_height(H1)) u_dut1 (
    .clk(clk), .reset(rst_n1), .pix_in(pix1), .pix_valid(pv1),
    .win_out(win1), .latency_out(lat1), .frame_done(fd1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [IB-1:0] img [2][32][32];
  int   mr [2];
  int   mc [2];
  win_t ewin [2];
  bit   evalid [2];
  bit   efd [2];
  bit   ehold [2];     // last accept produced a window, none since
  int   nwin [2];
  int   nobs [2];
  win_t wlog [$];      // model windows of DUT0, for literal pinning
  bit   fdlog [$];

  task automatic mreset(input int d);
    mr[d] = 0; mc[d] = 0;
    evalid[d] = 0; efd[d] = 0; ehold[d] = 0;
  endtask

  task automatic step(input int d, input bit v, input logic [IB-1:0] p,
                      input int w, input int h);
    int idx;
    evalid[d] = 0;
    efd[d]    = 0;
    if (v) begin
      img[d][mr[d]][mc[d]] = p;
      if (mr[d] >= 2 && mc[d] >= 2) begin
        for (int k = 0; k < 9; k++)
          ewin[d][k] = img[d][mr[d]-2+k/3][mc[d]-2+k%3];
        evalid[d] = 1;
        efd[d]    = (mr[d] == h-1) && (mc[d] == w-1);
        ehold[d]  = 1;
        nwin[d]++;
        if (d == 0) begin
          wlog.push_back(ewin[0]);
          fdlog.push_back(efd[0]);
        end
      end else begin
        ehold[d] = 0;
      end
      idx = mr[d]*w + mc[d] + 1;
      if (idx == w*h) idx = 0;
      mr[d] = idx / w;
      mc[d] = idx % w;
    end
  endtask

  always @(posedge clk or negedge rst_n0)
    if (!rst_n0) mreset(0); else step(0, pv0, pix0, W0, H0);

  always @(posedge clk or negedge rst_n1)
    if (!rst_n1) mreset(1); else step(1, pv1, pix1, W1, H1);

  function automatic logic [IB-1:0] dwin(input int d, input int k);
    return (d == 0) ? win0[k] : win1[k];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic l, f;
      l = (d == 0) ? lat0 : lat1;
      f = (d == 0) ? fd0 : fd1;
      chk($sformatf("dut%0d latency_out", d), 32'(l), 32'(evalid[d]));
      chk($sformatf("dut%0d frame_done", d), 32'(f), 32'(efd[d]));
      if (l === 1'b1) nobs[d]++;
      if (ehold[d])
        for (int k = 0; k < 9; k++)
          chk($sformatf("dut%0d win[%0d]", d, k), 32'(dwin(d, k)), 32'(ewin[d][k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input int v, input bit valid);
    @(negedge clk);
    if (d == 0) begin pix0 = IB'(v); pv0 = valid; end
    else        begin pix1 = IB'(v); pv1 = valid; end
  endtask

  task automatic frame0(input int base, input bit toggle);
    for (int i = 0; i < 16; i++) begin
      send(0, base + i, 1'b1);
      if (toggle) send(0, int'($urandom_range(0, 8191)), 1'b0);
    end
    send(0, 0, 1'b0);
  endtask

  task automatic chk_win(input string nm, input int i, input int e [9]);
    if (i >= wlog.size()) begin
      chk({nm, " present"}, 32'(wlog.size()), 32'(i + 1));
    end else begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("%s[%0d]", nm, k), 32'(wlog[i][k]), 32'(e[k]));
    end
  endtask

  int first_w [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int last_w  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int f2_w    [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
  int newest  [4] = '{10, 11, 14, 15};

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    pix0 = '0; pix1 = '0; pv0 = 1'b0; pv1 = 1'b0;
    nwin[0] = 0; nwin[1] = 0; nobs[0] = 0; nobs[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset latency_out", 32'(lat0), 32'd0);
    chk("reset frame_done", 32'(fd0), 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset win[%0d]", k), 32'(win0[k]), 32'd0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // Single 4x4 frame, valid every cycle.
    frame0(0, 1'b0);
    chk("s1 window count", 32'(wlog.size()), 32'd4);
    chk_win("s1 first window", 0, first_w);
    chk_win("s2 last window", 3, last_w);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk($sformatf("s2 newest[%0d]", i), 32'(wlog[i][8]), 32'(newest[i]));
      chk($sformatf("s2 frame_done[%0d]", i), 32'(fdlog[i]), 32'(i == 3));
    end
    wlog.delete(); fdlog.delete();

    // Same frame with pix_valid toggling.
    frame0(0, 1'b1);
    chk("s3 window count", 32'(wlog.size()), 32'd4);
    chk_win("s3 first window", 0, first_w);
    chk_win("s3 last window", 3, last_w);
    wlog.delete(); fdlog.delete();

    // Two back-to-back frames.
    for (int i = 0; i < 16; i++) send(0, i, 1'b1);
    for (int i = 0; i < 16; i++) send(0, 100 + i, 1'b1);
    send(0, 0, 1'b0);
    chk("s4 window count", 32'(wlog.size()), 32'd8);
    chk_win("s4 frame2 first window", 4, f2_w);
    wlog.delete(); fdlog.delete();

    // Reset mid-frame while a window is being presented.
    for (int i = 0; i <= 10; i++) send(0, i, 1'b1);
    @(posedge clk);
    #2;
    pv0 = 1'b0;
    rst_n0 = 1'b0;
    #1;
    chk("s5 latency_out at reset", 32'(lat0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    wlog.delete(); fdlog.delete();
    frame0(0, 1'b0);
    chk("s5 window count", 32'(wlog.size()), 32'd4);
    chk_win("s5 first window", 0, first_w);
    chk_win("s5 last window", 3, last_w);

    // 32x32 random frame with gaps, max value injected often.
    nwin[1] = 0; nobs[1] = 0;
    for (int i = 0; i < W1*H1; i++) begin
      int v;
      while ($urandom_range(0, 3) == 0) send(1, int'($urandom_range(0, 8191)), 1'b0);
      v = ($urandom_range(0, 7) == 0) ? 8191 : int'($urandom_range(0, 8191));
      send(1, v, 1'b1);
    end
    send(1, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("s6 model windows", 32'(nwin[1]), 32'd900);
    chk("s6 dut windows", 32'(nobs[1]), 32'd900);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
